// File: rtl/present_iter_core.sv
// present_iter_core
//   Iterative PRESENT block cipher (64-bit block, 80- or 128-bit key).
//   A single round datapath is reused for 31 rounds. The key schedule is
//   computed on the fly. Decryption first runs the schedule forward to K32
//   (KEYPRE), then applies inverse rounds while stepping the schedule back.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   request valid          / in_ready  core idle, can accept
//   mode       0 = encrypt, 1 = decrypt (sampled at accept)
//   key_in     cipher key             (sampled at accept)
//   data_in    plaintext/ciphertext   (sampled at accept)
//   out_valid  result valid           / out_ready sink accepts result
//   data_out   result, held stable while out_valid is high
//   busy       high in every state except IDLE
//   dbg_state  current FSM state (IDLE=0, KEYPRE=1, ENC=2, DEC=3, DONE=4)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Valid, once raised, stays high with stable payload until that
// edge; ready may be raised or lowered at any time.
module present_iter_core #(
    parameter int KEY_W = 80
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [KEY_W-1:0] key_in,
    input  logic [63:0]      data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      data_out,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    generate
        if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
            $error("present_iter_core: KEY_W must be 80 or 128");
        end
    endgenerate

    // Low bit of the 5-bit field that receives the round counter XOR.
    localparam int RC_LO = (KEY_W == 80) ? 15 : 62;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KEYPRE = 3'd1,
        S_ENC    = 3'd2,
        S_DEC    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        y = 4'h0;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        y = 4'h0;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox(x[4*i +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] inv_s_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = inv_sbox(x[4*i +: 4]);
        return y;
    endfunction

    // Bit j moves to (16*j) mod 63; bit 63 is a fixed point.
    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 63; j++) y[(16*j) % 63] = x[j];
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [63:0] inv_p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 63; j++) y[j] = x[(16*j) % 63];
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [KEY_W-1:0] key_upd(input logic [KEY_W-1:0] k,
                                                 input logic [4:0] rc);
        logic [KEY_W-1:0] t;
        t = (k << 61) | (k >> (KEY_W - 61));
        t[KEY_W-1 -: 4] = sbox(t[KEY_W-1 -: 4]);
        if (KEY_W == 128) t[KEY_W-5 -: 4] = sbox(t[KEY_W-5 -: 4]);
        t[RC_LO +: 5] = t[RC_LO +: 5] ^ rc;
        return t;
    endfunction

    // Undo in reverse order: rc XOR, S-box(es), then the rotation.
    function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k,
                                                 input logic [4:0] rc);
        logic [KEY_W-1:0] t;
        t = k;
        t[RC_LO +: 5] = t[RC_LO +: 5] ^ rc;
        t[KEY_W-1 -: 4] = inv_sbox(t[KEY_W-1 -: 4]);
        if (KEY_W == 128) t[KEY_W-5 -: 4] = inv_sbox(t[KEY_W-5 -: 4]);
        return (t >> 61) | (t << (KEY_W - 61));
    endfunction

    state_t           r_fsm;
    logic [63:0]      r_state;
    logic [KEY_W-1:0] r_key;
    logic [4:0]       r_rc;
    logic [63:0]      r_data_out;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             r_busy;

    logic [63:0]      w_rk;
    logic [63:0]      w_enc_state;
    logic [63:0]      w_dec_state;
    logic [KEY_W-1:0] w_key_next;
    logic [KEY_W-1:0] w_key_prev;

    assign w_rk        = r_key[KEY_W-1 -: 64];
    assign w_enc_state = p_layer(s_layer(r_state ^ w_rk));
    assign w_dec_state = inv_s_layer(inv_p_layer(r_state ^ w_rk));
    assign w_key_next  = key_upd(r_key, r_rc);
    assign w_key_prev  = key_inv(r_key, r_rc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fsm       <= S_IDLE;
            r_state     <= '0;
            r_key       <= '0;
            r_rc        <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_state    <= data_in;
                        r_key      <= key_in;
                        r_rc       <= 5'd1;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_fsm      <= mode ? S_KEYPRE : S_ENC;
                    end
                end
                S_ENC: begin
                    r_state <= w_enc_state;
                    r_key   <= w_key_next;
                    if (r_rc == 5'd31) begin
                        // Final whitening with K32 folded into the output register.
                        r_data_out  <= w_enc_state ^ w_key_next[KEY_W-1 -: 64];
                        r_out_valid <= 1'b1;
                        r_fsm       <= S_DONE;
                    end else begin
                        r_rc <= r_rc + 5'd1;
                    end
                end
                S_KEYPRE: begin
                    r_key <= w_key_next;
                    // rc stays at 31 so DEC starts by undoing the last update.
                    if (r_rc == 5'd31) r_fsm <= S_DEC;
                    else               r_rc  <= r_rc + 5'd1;
                end
                S_DEC: begin
                    r_state <= w_dec_state;
                    r_key   <= w_key_prev;
                    if (r_rc == 5'd1) begin
                        r_data_out  <= w_dec_state ^ w_key_prev[KEY_W-1 -: 64];
                        r_out_valid <= 1'b1;
                        r_fsm       <= S_DONE;
                    end else begin
                        r_rc <= r_rc - 5'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_rc        <= '0;
                        r_fsm       <= S_IDLE;
                    end
                end
                default: begin
                    r_fsm       <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign busy      = r_busy;
    assign dbg_state = r_fsm;

endmodule

// File: doc/present_iter_core.md
Name: present_iter_core

Overview:
- Iterative, parametrised PRESENT block-cipher core: one round datapath, reused over 31 rounds, with an on-the-fly key schedule.
- Supports 80- and 128-bit keys, and both encryption and decryption. Decryption uses a key pre-pass followed by inverse rounds.
- Sits between a host-side valid/ready source and sink. Replaces the fully unrolled 31-stage encryptor where area matters.

Parameters:
- KEY_W, 80, key width; legal values are 80 and 128 only. Any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  core can accept a request
- mode  input  1  0 = encrypt, 1 = decrypt; sampled at accept
- key_in  input  KEY_W  cipher key; sampled at accept
- data_in  input  64  plaintext or ciphertext; sampled at accept
- out_valid  output  1  result valid
- out_ready  input  1  sink accepts the result
- data_out  output  64  result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset = 0, asynchronous):
  - state returns to IDLE; round counter = 0; key and state registers = 0.
  - data_out = 0, out_valid = 0, busy = 0, in_ready = 1.
  - Reset mid-operation aborts the request with no output; there is no partial result.
- Round function definitions:
  - Round key K_i = key_reg[KEY_W-1:KEY_W-64].
  - S = the standard PRESENT 4-bit S-box (C56B90AD3EF84712), applied to all 16 nibbles.
  - P: bit j moves to position (16*j) mod 63; bit 63 stays fixed.
  - invS and invP are the exact inverses of S and P.
- Key update with round counter rc (5-bit):
  - KEY_W = 80: rotate left 61; S on bits [79:76]; bits [19:15] ^= rc.
  - KEY_W = 128: rotate left 61; S on [127:124] and on [123:120]; bits [66:62] ^= rc.
  - Inverse update: undo the rc XOR, then undo the S-box(es), then rotate right 61.
- FSM states: IDLE, KEYPRE, ENC, DEC, DONE.
- IDLE:
  - in_ready = 1.
  - Accept on in_valid & in_ready: load state_reg = data_in, key_reg = key_in (K1), rc = 1.
  - Next state is ENC if mode = 0, KEYPRE if mode = 1.
- ENC, rc = 1..31, one round per cycle:
  - state_reg <= P(S(state_reg ^ K_rc)); key_reg <= update(key_reg, rc); rc++.
  - On the rc = 31 edge: data_out <= P(S(state_reg ^ K31)) ^ K32, then go to DONE.
- KEYPRE, 31 cycles: key_reg <= update(key_reg, rc); rc++. Ends with key_reg = K32 and rc = 31; then go to DEC.
- DEC, rc = 31 down to 1:
  - First DEC edge (rc = 31): state_reg <= invS(invP(state_reg ^ K32)); key_reg <= invupdate(key_reg, 31), giving K31; rc--.
  - Each later edge: state_reg <= invS(invP(state_reg ^ K_(rc+1))), where K_(rc+1) is the current key_reg; key_reg <= invupdate(key_reg, rc), giving K_rc; rc--.
  - On the rc = 1 edge: data_out <= invS(invP(state_reg ^ K2)) ^ K1, with K1 = invupdate(K2, 1); then go to DONE.
- Latency, with the accept edge = T:
  - Encrypt: out_valid is high from edge T+31.
  - Decrypt: out_valid is high from edge T+62.
- DONE:
  - out_valid = 1; data_out is stable and held until out_ready = 1.
  - On the out_valid & out_ready edge: out_valid <= 0, go to IDLE. in_ready reasserts the following cycle.
  - No accept is possible in the same cycle as the output handshake.
- in_ready = 0 in all states except IDLE. Inputs that change after the accept edge are ignored.
- busy = 1 from the edge after accept until the output handshake edge.
- rc is 5 bits and never wraps: the maximum in ENC/KEYPRE is 31, and the minimum in DEC is 1.

Test Plan:
- KEY_W = 80, encrypt, key 0, pt 0 -> data_out 5579C1387B228445; out_valid rises exactly 31 cycles after accept.
- KEY_W = 80, encrypt, key all-F, pt all-F -> 3333DCD3213210D2.
- KEY_W = 80, encrypt, key 0, pt all-F -> A112FFC72F68417B.
- KEY_W = 80, decrypt, key all-F, ct 3333DCD3213210D2 -> all-F; out_valid rises 62 cycles after accept.
- KEY_W = 128, encrypt, key 0, pt 0 -> 96DB702A2E6900AF; decrypting that ciphertext returns 0.
- Control checks:
  - Hold out_ready = 0 for 10 cycles: data_out stable, in_ready stays 0.
  - Toggle data_in/key_in mid-round: result unchanged.
  - Assert reset low at round 15: out_valid = 0 and in_ready = 1 immediately; the next request produces the correct result.
